// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand/result widths, FSM state encoding
// and the divide-by-zero quotient value.
package calc_pkg;

  localparam int unsigned CALC_OPERAND_W = 4;
  localparam int unsigned CALC_RESULT_W  = 8;

  localparam logic [CALC_RESULT_W-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module divider_step
  import calc_pkg::*;
#(
  parameter int unsigned DIVISOR_W = CALC_OPERAND_W
) (
  input  logic [DIVISOR_W:0]   partial,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   partial_next_c,
  output logic                 q_bit_c
);

  // One extra bit beyond the partial width carries the borrow of the trial.
  localparam int unsigned TRIAL_W = DIVISOR_W + 2;

  logic [TRIAL_W-1:0] shifted;
  logic [TRIAL_W-1:0] trial;

  always_comb begin
    shifted        = {partial, bit_in};
    trial          = shifted - TRIAL_W'(divisor);
    q_bit_c        = ~trial[TRIAL_W-1];
    partial_next_c = q_bit_c ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/sequential_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and a flagged divide-by-zero shortcut.
module sequential_divider
  import calc_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = CALC_RESULT_W,
  parameter int unsigned DIVISOR_W  = CALC_OPERAND_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W  = $clog2(DIVIDEND_W + 1);
  localparam int unsigned PART_W = DIVISOR_W + 1;

  div_state_e state, state_next;

  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVISOR_W-1:0]  dvs_r;
  logic [PART_W-1:0]     part_r;
  logic [PART_W-1:0]     part_next_c;
  logic [CNT_W-1:0]      cnt;
  logic                  q_bit_c;
  logic                  accept;
  logic                  accept_dbz;
  logic                  last_iter;

  divider_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .partial        (part_r),
    .bit_in         (dvd_sr[DIVIDEND_W-1]),
    .divisor        (dvs_r),
    .partial_next_c (part_next_c),
    .q_bit_c        (q_bit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus the load/finish strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    accept_dbz = 1'b0;
    last_iter  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            accept_dbz = 1'b1;
            state_next = DONE;
          end else begin
            accept     = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (cnt == CNT_W'(DIVIDEND_W - 1)) begin
          last_iter  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Quotient bits are shifted into the vacated low end of the dividend register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sr      <= '0;
      dvs_r       <= '0;
      part_r      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (accept) begin
        dvd_sr      <= dividend;
        dvs_r       <= divisor;
        part_r      <= '0;
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end else if (accept_dbz) begin
        quotient    <= DIVIDEND_W'(DIV_ZERO_QUOTIENT);
        remainder   <= dividend[DIVISOR_W-1:0];
        div_by_zero <= 1'b1;
      end else if (state == RUN) begin
        dvd_sr <= {dvd_sr[DIVIDEND_W-2:0], q_bit_c};
        part_r <= part_next_c;
        cnt    <= cnt + CNT_W'(1);
        if (last_iter) begin
          quotient  <= {dvd_sr[DIVIDEND_W-2:0], q_bit_c};
          remainder <= part_next_c[DIVISOR_W-1:0];
        end
      end
    end
  end

endmodule
